// File: rtl/dcore_bus_pkg.sv
// Shared definitions for the dcore bus arbiter: widths, FSM state encoding,
// bus operation / address-space encodings and a saturating counter helper.
package dcore_bus_pkg;

    localparam int DCORE_DATA_WIDTH = 512;
    localparam int DCORE_WORDSIZE   = 64;
    localparam int DCORE_TAG_WIDTH  = 13;
    localparam int DCORE_NREQ       = 2;
    localparam int DCORE_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } rw_e;

    typedef enum logic [1:0] {
        MEMORY = 2'd0,
        MMIO   = 2'd1,
        PORT   = 2'd2,
        IRQ    = 2'd3
    } space_e;

    // Debug counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. The pointer names the preferred requester;
// after a grant it moves to the requester that did not win.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic pointer_r;

    // Preferred requester wins a tie; a lone requester wins regardless.
    always_comb begin
        grant_valid = req[0] | req[1];
        if (req[pointer_r]) begin
            grant_idx = pointer_r;
        end else begin
            grant_idx = ~pointer_r;
        end
    end

    // Pointer register: hand preference to the other side after each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            pointer_r <= 1'b0;
        end else if (grant_en && grant_valid) begin
            pointer_r <= ~grant_idx;
        end else begin
            pointer_r <= pointer_r;
        end
    end

endmodule

// File: rtl/dcore_bus_arbiter.sv
// Arbitrates two requesters onto a single cache port with one transaction
// in flight. Requests and responses are muxed combinationally from/to the
// latched owner; the tag is carried through untouched and never used for routing.
module dcore_bus_arbiter
    import dcore_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DCORE_DATA_WIDTH,
    parameter int WORDSIZE   = DCORE_WORDSIZE,
    parameter int TAG_WIDTH  = DCORE_TAG_WIDTH,
    parameter int NREQ       = DCORE_NREQ
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NREQ-1:0]                  u_reqcyc,
    input  logic [WORDSIZE-1:0]              u_req      [NREQ],
    input  logic [DATA_WIDTH-1:0]            u_reqdata  [NREQ],
    input  logic [DATA_WIDTH/WORDSIZE-1:0]   u_reqwrite [NREQ],
    input  logic [TAG_WIDTH-1:0]             u_reqtag   [NREQ],
    output logic [NREQ-1:0]                  u_reqack,
    output logic [NREQ-1:0]                  u_respcyc,
    output logic [DATA_WIDTH-1:0]            u_resp     [NREQ],
    output logic [TAG_WIDTH-1:0]             u_resptag  [NREQ],
    input  logic [NREQ-1:0]                  u_respack,
    output logic                             c_reqcyc,
    output logic [WORDSIZE-1:0]              c_req,
    output logic [DATA_WIDTH-1:0]            c_reqdata,
    output logic [DATA_WIDTH/WORDSIZE-1:0]   c_reqwrite,
    output logic [TAG_WIDTH-1:0]             c_reqtag,
    input  logic                             c_reqack,
    input  logic                             c_respcyc,
    input  logic [DATA_WIDTH-1:0]            c_resp,
    input  logic [TAG_WIDTH-1:0]             c_resptag,
    output logic                             c_respack,
    output logic [DCORE_CNT_WIDTH-1:0]       grant_cnt  [NREQ]
);

    localparam int MASK_WIDTH = DATA_WIDTH / WORDSIZE;

    arb_state_e state_r;
    arb_state_e state_s;
    logic       owner_r;
    logic       grant_valid_s;
    logic       grant_idx_s;
    logic       handshake_s;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .reset       (reset),
        .req         (u_reqcyc[1:0]),
        .grant_en    (state_r == IDLE),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Next-state and bus muxing; reset blanks every output in its own cycle.
    always_comb begin
        state_s     = state_r;
        handshake_s = 1'b0;
        c_reqcyc    = 1'b0;
        c_req       = {WORDSIZE{1'b0}};
        c_reqdata   = {DATA_WIDTH{1'b0}};
        c_reqwrite  = {MASK_WIDTH{1'b0}};
        c_reqtag    = {TAG_WIDTH{1'b0}};
        c_respack   = 1'b0;
        u_reqack    = {NREQ{1'b0}};
        u_respcyc   = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            u_resp[i]    = {DATA_WIDTH{1'b0}};
            u_resptag[i] = {TAG_WIDTH{1'b0}};
        end
        if (reset) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        state_s = REQ;
                    end else begin
                        state_s = IDLE;
                    end
                end
                REQ: begin
                    c_req      = u_req[owner_r];
                    c_reqdata  = u_reqdata[owner_r];
                    c_reqwrite = u_reqwrite[owner_r];
                    c_reqtag   = u_reqtag[owner_r];
                    if (!u_reqcyc[owner_r]) begin
                        // Owner withdrew before the cache took it: abort.
                        state_s = IDLE;
                    end else begin
                        c_reqcyc = 1'b1;
                        if (c_reqack) begin
                            u_reqack[owner_r] = 1'b1;
                            handshake_s       = 1'b1;
                            state_s           = RESP;
                        end else begin
                            state_s = REQ;
                        end
                    end
                end
                RESP: begin
                    u_respcyc[owner_r] = c_respcyc;
                    u_resp[owner_r]    = c_resp;
                    u_resptag[owner_r] = c_resptag;
                    c_respack          = u_respack[owner_r];
                    if (c_respcyc && u_respack[owner_r]) begin
                        state_s = IDLE;
                    end else begin
                        state_s = RESP;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and owner registers; owner is captured only when a grant is made.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && grant_valid_s) begin
                owner_r <= grant_idx_s;
            end else begin
                owner_r <= owner_r;
            end
        end
    end

    // Per-requester saturating count of accepted requests.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                grant_cnt[i] <= 16'd0;
            end else if (handshake_s && (int'(owner_r) == i)) begin
                grant_cnt[i] <= sat_inc16(grant_cnt[i]);
            end else begin
                grant_cnt[i] <= grant_cnt[i];
            end
        end
    end

endmodule
